id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, sitting between the IF/ID register and the ID/EX register. Holds the 32×32 register file and decodes the main control signals. Sign-extends the immediate and detects load-use hazards, issuing a stall and a control bubble. Its outputs are combinational and are captured by the ID/EX register on the next `clk` edge.

## Interface
Parameters:
- `NREG`, 32: register-file depth; register 0 is hardwired to zero.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pcin` input 32: PC+4 from IF/ID.
- `instr` input 32: instruction from IF/ID.
- `wb_regwrite` input 1: write-back write enable.
- `wb_addr` input 5: write-back destination register.
- `wb_data` input 32: write-back data.
- `ex_memread` input 1: memread of the instruction currently in ID/EX.
- `ex_rt` input 5: rt field of the instruction currently in ID/EX.
- `pc` output 32: `pcin` passed through.
- `regd0` output 32: read data for rs (`instr[25:21]`).
- `regd1` output 32: read data for rt (`instr[20:16]`).
- `instex` output 32: sign-extended `instr[15:0]`.
- `inst0` output 5: `instr[20:16]`.
- `inst1` output 5: `instr[15:11]`.
- `regdst`, `alusrc`, `branch`, `memread`, `memwrite`, `regwrite`, `memtoreg` output 1 each: decoded control.
- `aluop` output 2: ALU operation class.
- `stall` output 1: hold PC and IF/ID this cycle.
- `stall_cnt` output 16: saturating count of stall cycles.

## Operation
- Decode on opcode `instr[31:26]`. Any signal not listed for an opcode is 0.
  - `000000` (R-type): regdst=1, regwrite=1, aluop=10.
  - `100011` (lw): alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00.
  - `101011` (sw): alusrc=1, memwrite=1, aluop=00.
  - `000100` (beq): branch=1, aluop=01.
  - `001000` (addi): alusrc=1, regwrite=1, aluop=00.
  - Any other opcode: all control 0, which makes it a NOP.
- Register file:
  - A write occurs on the `clk` edge when `wb_regwrite` is high and `wb_addr` is not 0. Writes to register 0 are ignored, and register 0 always reads 0.
  - Both read ports are combinational.
  - Write-first bypass: if a read address equals `wb_addr`, `wb_regwrite` is high and the address is not 0, that port returns `wb_data` in the same cycle.
- Hazard detection:
  - `stall` = `ex_memread` && `ex_rt` != 0 && (`ex_rt` == rs || (`ex_rt` == rt && opcode ∈ {R-type, sw, beq})).
  - While `stall` is high, all control outputs (`regdst`, `aluop`, `alusrc`, `branch`, `memread`, `memwrite`, `regwrite`, `memtoreg`) are forced to 0, so ID/EX captures a bubble.
  - Data outputs (`pc`, `regd0`, `regd1`, `instex`, `inst0`, `inst1`) are unaffected by `stall`.
- `stall_cnt` increments by 1 on each `clk` edge where `stall` is high, and saturates at 16'hFFFF.
- Reset:
  - While `rst` is high, the clock edge clears all registers to 0 and clears `stall_cnt` to 0. Write-back writes in that cycle are ignored.
  - Combinationally during `rst`: all control outputs are 0, `stall` is 0, `regd0` and `regd1` are 0, and the bypass is disabled.
  - `pc`, `instex`, `inst0` and `inst1` still follow their inputs.

## Timing
- Decode, read, bypass and stall are all zero-latency combinational paths from the inputs to the outputs.
- Register write latency: data written at edge N is visible on the read ports from edge N onward. In the cycle before edge N it is already visible through the bypass.
- A load-use hazard produces exactly one `stall` cycle. After that cycle the lw has left ID/EX, so `ex_memread` drops and `stall` drops; no internal state holds the stall.
- Reset mid-operation: the first edge with `rst` high clears everything, including `stall_cnt`. A `stall` asserted in the same cycle does not increment the count.
- Writing and reading the same register in one cycle returns the new value (bypass).
- Writing register 0 and reading it in the same cycle returns 0.

## Test plan
- Reset with `wb_regwrite`=1, `wb_addr`=5 → after release, reg5 reads 0, `stall_cnt`=0 and all control outputs are 0.
- Write `wb_addr`=3 with `wb_data`=32'hDEADBEEF while `instr` rs=3 → `regd0`=DEADBEEF in that same cycle and on every later cycle. Writing `wb_addr`=0 → `regd0`=0 when rs=0.
- `instr`=32'h8C22FFFC (lw $2,-4($1)) → memread=1, memtoreg=1, regwrite=1, alusrc=1, aluop=00, regdst=0, `instex`=32'hFFFFFFFC, `inst0`=2.
- `ex_memread`=1, `ex_rt`=2, `instr`=add $3,$2,$4 → `stall`=1 and all control outputs 0. The following cycle, with `ex_memread`=0 → `stall`=0, regdst=1, regwrite=1, aluop=10.
- `ex_memread`=1, `ex_rt`=2, `instr`=addi $2,$5,1 (rt=2, rs=5) → `stall`=0. With `ex_rt`=0 → `stall`=0.
- Hold `stall` high for 70000 cycles → `stall_cnt`=16'hFFFF. A subsequent `rst` → `stall_cnt`=0.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
// Holds the 32x32 register file with write-first bypass, decodes the main
// control word, sign-extends the immediate and detects load-use hazards.
// All outputs are combinational; the ID/EX register captures them.
module id_stage #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcin,
   input  logic [31:0] instr,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   output logic [31:0] pc,
   output logic [31:0] regd0,
   output logic [31:0] regd1,
   output logic [31:0] instex,
   output logic [4:0]  inst0,
   output logic [4:0]  inst1,
   output logic        regdst,
   output logic        alusrc,
   output logic        branch,
   output logic        memread,
   output logic        memwrite,
   output logic        regwrite,
   output logic        memtoreg,
   output logic [1:0]  aluop,
   output logic        stall,
   output logic [15:0] stall_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [31:0] regs_r [NREG];
   logic [15:0] stall_cnt_r;

   logic [5:0]  opcode_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic        wb_active_s;
   logic        rt_used_s;
   logic        stall_s;
   logic [8:0]  ctrl_dec_s;
   logic [8:0]  ctrl_s;

   assign opcode_s = instr[31:26];
   assign rs_s     = instr[25:21];
   assign rt_s     = instr[20:16];

   // A write-back is effective only outside reset and never to register 0.
   assign wb_active_s = wb_regwrite && (wb_addr != 5'd0) && !rst;

   // Register file update and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= 32'd0;
         end
         stall_cnt_r <= 16'd0;
      end else begin
         if (wb_active_s) begin
            regs_r[wb_addr] <= wb_data;
         end
         if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end
      end
   end

   // Read ports: zero in reset or for r0, bypass from write-back, else array.
   always_comb begin
      regd0 = 32'd0;
      regd1 = 32'd0;
      if (rst || (rs_s == 5'd0)) begin
         regd0 = 32'd0;
      end else if (wb_active_s && (wb_addr == rs_s)) begin
         regd0 = wb_data;
      end else begin
         regd0 = regs_r[rs_s];
      end
      if (rst || (rt_s == 5'd0)) begin
         regd1 = 32'd0;
      end else if (wb_active_s && (wb_addr == rt_s)) begin
         regd1 = wb_data;
      end else begin
         regd1 = regs_r[rt_s];
      end
   end

   // Opcodes that actually read rt as a source operand.
   always_comb begin
      rt_used_s = 1'b0;
      case (opcode_s)
         OP_RTYPE: rt_used_s = 1'b1;
         OP_SW:    rt_used_s = 1'b1;
         OP_BEQ:   rt_used_s = 1'b1;
         default:  rt_used_s = 1'b0;
      endcase
   end

   // Load-use hazard: the load in EX writes a register this instruction reads.
   always_comb begin
      stall_s = 1'b0;
      if (rst) begin
         stall_s = 1'b0;
      end else begin
         stall_s = ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == rs_s) || ((ex_rt == rt_s) && rt_used_s));
      end
   end

   // Main decoder; bit order {regdst,alusrc,branch,memread,memwrite,regwrite,memtoreg,aluop}.
   always_comb begin
      ctrl_dec_s = 9'b000000000;
      case (opcode_s)
         OP_RTYPE: ctrl_dec_s = 9'b100001010;
         OP_LW:    ctrl_dec_s = 9'b010101100;
         OP_SW:    ctrl_dec_s = 9'b010010000;
         OP_BEQ:   ctrl_dec_s = 9'b001000001;
         OP_ADDI:  ctrl_dec_s = 9'b010001000;
         default:  ctrl_dec_s = 9'b000000000;
      endcase
   end

   // Reset or stall turns the instruction into a bubble.
   always_comb begin
      ctrl_s = 9'b000000000;
      if (rst || stall_s) begin
         ctrl_s = 9'b000000000;
      end else begin
         ctrl_s = ctrl_dec_s;
      end
   end

   assign {regdst, alusrc, branch, memread, memwrite, regwrite, memtoreg, aluop} = ctrl_s;

   assign pc        = pcin;
   assign instex    = {{16{instr[15]}}, instr[15:0]};
   assign inst0     = instr[20:16];
   assign inst1     = instr[15:11];
   assign stall     = stall_s;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;

   logic        clk;
   logic        rst;
   logic [31:0] pcin;
   logic [31:0] instr;
   logic        wb_regwrite;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_memread;
   logic [4:0]  ex_rt;
   logic [31:0] pc;
   logic [31:0] regd0;
   logic [31:0] regd1;
   logic [31:0] instex;
   logic [4:0]  inst0;
   logic [4:0]  inst1;
   logic        regdst, alusrc, branch, memread, memwrite, regwrite, memtoreg;
   logic [1:0]  aluop;
   logic        stall;
   logic [15:0] stall_cnt;

   int checks_cnt;
   int errors_cnt;

   // Control word in order {regdst,alusrc,branch,memread,memwrite,regwrite,memtoreg,aluop}.
   logic [8:0] ctrl;
   assign ctrl = {regdst, alusrc, branch, memread, memwrite, regwrite, memtoreg, aluop};

   localparam logic [8:0] C_NONE = 9'b000000000;
   localparam logic [8:0] C_R    = 9'b100001010;
   localparam logic [8:0] C_LW   = 9'b010101100;
   localparam logic [8:0] C_SW   = 9'b010010000;
   localparam logic [8:0] C_BEQ  = 9'b001000001;
   localparam logic [8:0] C_ADDI = 9'b010001000;

   // NOP-opcode instruction reading rs=3, rt=3.
   localparam logic [31:0] I_NOP_R3 = 32'hFC630000;
   // NOP-opcode instruction reading rs=5.
   localparam logic [31:0] I_NOP_R5 = 32'hFCA00000;
   // NOP-opcode instruction reading rs=0.
   localparam logic [31:0] I_NOP_R0 = 32'hFC000000;
   localparam logic [31:0] I_LW     = 32'h8C22FFFC; // lw $2,-4($1)
   localparam logic [31:0] I_ADD    = 32'h00441820; // add $3,$2,$4
   localparam logic [31:0] I_ADDI   = 32'h20A20001; // addi $2,$5,1
   localparam logic [31:0] I_SW     = 32'hACA20000; // sw $2,0($5)
   localparam logic [31:0] I_BEQ    = 32'h10A60003; // beq $5,$6,3

   id_stage #(.NREG(32)) dut (
      .clk(clk), .rst(rst), .pcin(pcin), .instr(instr),
      .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .pc(pc), .regd0(regd0), .regd1(regd1), .instex(instex),
      .inst0(inst0), .inst1(inst1),
      .regdst(regdst), .alusrc(alusrc), .branch(branch), .memread(memread),
      .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
      .aluop(aluop), .stall(stall), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and step away from it before driving/sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks_cnt  = 0;
      errors_cnt  = 0;
      rst         = 1'b1;
      pcin        = 32'h00000100;
      instr       = 32'h00A00000; // R-type reading rs=5
      wb_regwrite = 1'b1;
      wb_addr     = 5'd5;
      wb_data     = 32'h12345678;
      ex_memread  = 1'b1;
      ex_rt       = 5'd5;
      #2;
      // During reset: bubble, no stall, no bypass, data fields still pass through.
      check("rst_ctrl",  {23'd0, ctrl}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_regd0", regd0, 32'd0);
      check("rst_pc",    pc, 32'h00000100);
      tick();
      tick();
      rst         = 1'b0;
      wb_regwrite = 1'b0;
      ex_memread  = 1'b0;
      ex_rt       = 5'd0;
      instr       = I_NOP_R5;
      #1;
      check("post_rst_reg5",  regd0, 32'd0);
      check("post_rst_cnt",   {16'd0, stall_cnt}, 32'd0);
      check("post_rst_ctrl",  {23'd0, ctrl}, 32'd0);

      // Write reg3 and read it through the bypass in the same cycle.
      instr       = I_NOP_R3;
      wb_regwrite = 1'b1;
      wb_addr     = 5'd3;
      wb_data     = 32'hDEADBEEF;
      #1;
      check("bypass_rd0", regd0, 32'hDEADBEEF);
      check("bypass_rd1", regd1, 32'hDEADBEEF);
      tick();
      wb_regwrite = 1'b0;
      wb_data     = 32'h0;
      #1;
      check("stored_rd0_a", regd0, 32'hDEADBEEF);
      tick();
      check("stored_rd0_b", regd0, 32'hDEADBEEF);

      // Write to r0 is dropped, both in the bypass and in the array.
      instr       = I_NOP_R0;
      wb_regwrite = 1'b1;
      wb_addr     = 5'd0;
      wb_data     = 32'hFFFFFFFF;
      #1;
      check("r0_bypass", regd0, 32'd0);
      tick();
      wb_regwrite = 1'b0;
      #1;
      check("r0_after", regd0, 32'd0);

      // lw decode, sign extension and rt field.
      instr = I_LW;
      #1;
      check("lw_ctrl",   {23'd0, ctrl}, {23'd0, C_LW});
      check("lw_instex", instex, 32'hFFFFFFFC);
      check("lw_inst0",  {27'd0, inst0}, 32'd2);
      check("lw_inst1",  {27'd0, inst1}, 32'd31);

      // Load-use on rs: stall and bubble for exactly one cycle.
      instr      = I_ADD;
      ex_memread = 1'b1;
      ex_rt      = 5'd2;
      #1;
      check("lu_stall",  {31'd0, stall}, 32'd1);
      check("lu_ctrl",   {23'd0, ctrl}, 32'd0);
      check("lu_inst1",  {27'd0, inst1}, 32'd3);
      tick();
      ex_memread = 1'b0;
      #1;
      check("lu_release_stall", {31'd0, stall}, 32'd0);
      check("lu_release_ctrl",  {23'd0, ctrl}, {23'd0, C_R});
      check("lu_cnt",           {16'd0, stall_cnt}, 32'd1);

      // addi writes rt, so a match on rt alone is not a hazard.
      instr      = I_ADDI;
      ex_memread = 1'b1;
      ex_rt      = 5'd2;
      #1;
      check("addi_nostall", {31'd0, stall}, 32'd0);
      check("addi_ctrl",    {23'd0, ctrl}, {23'd0, C_ADDI});
      ex_rt = 5'd0;
      #1;
      check("rt0_nostall",  {31'd0, stall}, 32'd0);

      // sw reads rt, so an rt match stalls.
      instr = I_SW;
      ex_rt = 5'd2;
      #1;
      check("sw_stall", {31'd0, stall}, 32'd1);
      tick();
      ex_memread = 1'b0;
      #1;
      check("sw_ctrl", {23'd0, ctrl}, {23'd0, C_SW});
      check("sw_cnt",  {16'd0, stall_cnt}, 32'd2);

      instr = I_BEQ;
      #1;
      check("beq_ctrl",   {23'd0, ctrl}, {23'd0, C_BEQ});
      check("beq_instex", instex, 32'h00000003);

      // Hold the hazard until the counter saturates.
      instr      = I_ADD;
      ex_memread = 1'b1;
      ex_rt      = 5'd2;
      for (int i = 0; i < 65532; i++) begin
         tick();
      end
      check("cnt_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
      tick();
      check("cnt_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      check("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

      // Reset with the hazard still present clears the counter and registers.
      rst = 1'b1;
      #1;
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      tick();
      rst        = 1'b0;
      ex_memread = 1'b0;
      instr      = I_NOP_R3;
      #1;
      check("rst_mid_cnt",  {16'd0, stall_cnt}, 32'd0);
      check("rst_mid_reg3", regd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
